// File: rtl/fpadder_driver_pkg.sv
// Shared types and constants for the fpadder driver.
// State enum plus the adder's zero and NaN encodings.
package fpadder_pkg;

    typedef enum logic [1:0] {
        WAIT_RDY,
        WIN2,
        BSLOT,
        BUSY
    } fpdrv_state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'hFFFF_FFFF;

endpackage

// File: rtl/fpadder_driver_if.sv
// Operand and result valid/ready streams of the fpadder driver.
// master is the controller side, slave is the driver side.
interface fpadder_driver_if;

    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_sum;

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_sum
    );

    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_sum
    );

endinterface

// File: rtl/fpadder_driver.sv
// Sequences operand pairs into the free-running serial fpadder.
// Optional watchdog on a stuck adder: define FPADDER_DRV_TIMEOUT_EN.
module fpadder_driver
    import fpadder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic            clock,
    input  logic            nreset,
    fpadder_driver_if.slave drv,
    output logic [31:0]     add_a,
    input  logic            add_ready,
    input  logic [31:0]     add_sum,
    output logic            timeout_err
);

    typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] wd_t;

    fpdrv_state_t r_state;
    logic         r_ready_d;
    logic         r_pend_valid;
    logic [31:0]  r_pend_a;
    logic [31:0]  r_pend_b;
    logic [31:0]  r_b_lat;
    logic         r_issued;
    logic [31:0]  r_add_a;
    logic         r_res_valid;
    logic [31:0]  r_res_sum;

    logic w_rise;
    logic w_start;
    logic w_capture;
    logic w_issue;
    logic w_accept;

    // A rise in BUSY both completes the old window and opens the next one.
    assign w_rise    = add_ready & ~r_ready_d;
    assign w_start   = w_rise & ((r_state == WAIT_RDY) | (r_state == BUSY));
    assign w_capture = w_rise & (r_state == BUSY) & r_issued;
    assign w_issue   = r_pend_valid & ~r_res_valid & ~w_capture;
    assign w_accept  = drv.op_valid & ~r_pend_valid;

    assign drv.op_ready  = ~r_pend_valid;
    assign drv.res_valid = r_res_valid;
    assign drv.res_sum   = r_res_sum;
    assign add_a         = r_add_a;

`ifdef FPADDER_DRV_TIMEOUT_EN
    wd_t  r_wd;
    logic r_timeout;
    logic w_wd_hit;

    assign w_wd_hit = (r_state == BUSY) & ~w_rise
                    & (r_wd == wd_t'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != BUSY) || w_rise)
                r_wd <= '0;
            else
                r_wd <= r_wd + 1'b1;
            if (w_wd_hit)
                r_timeout <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state      <= WAIT_RDY;
            r_ready_d    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_a     <= FP_ZERO;
            r_pend_b     <= FP_ZERO;
            r_b_lat      <= FP_ZERO;
            r_issued     <= 1'b0;
            r_add_a      <= FP_ZERO;
            r_res_valid  <= 1'b0;
            r_res_sum    <= FP_ZERO;
        end else begin
            r_ready_d <= add_ready;

            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_a     <= drv.op_a;
                r_pend_b     <= drv.op_b;
            end else if (w_start && w_issue) begin
                r_pend_valid <= 1'b0;
            end

            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= add_sum;
            end else if (drv.res_ready) begin
                r_res_valid <= 1'b0;
            end

            // Idle windows feed 0+0 so the adder takes its fast path.
            if (w_start) begin
                r_issued <= w_issue;
                r_add_a  <= w_issue ? r_pend_a : FP_ZERO;
                r_b_lat  <= r_pend_b;
            end

            unique case (r_state)
                WAIT_RDY: begin
                    if (w_rise)
                        r_state <= WIN2;
                end
                WIN2: begin
                    r_add_a <= r_issued ? r_b_lat : FP_ZERO;
                    r_state <= BSLOT;
                end
                BSLOT: begin
                    r_state <= BUSY;
                end
                BUSY: begin
                    if (w_rise) begin
                        r_state <= WIN2;
                    end
`ifdef FPADDER_DRV_TIMEOUT_EN
                    else if (w_wd_hit) begin
                        r_issued <= 1'b0;
                        r_state  <= WAIT_RDY;
                    end
`endif
                end
                default: begin
                    r_state <= WAIT_RDY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpadder_driver.sv
// Bench for fpadder_driver: behavioural free-running adder plus a result scoreboard.
// Timeout section builds only with FPADDER_DRV_TIMEOUT_EN.
module tb_fpadder_driver;
    import fpadder_pkg::*;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [31:0] add_a;
    logic        add_ready;
    logic [31:0] add_sum;
    logic        timeout_err;

    fpadder_driver_if bus ();

    fpadder_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .drv         (bus),
        .add_a       (add_a),
        .add_ready   (add_ready),
        .add_sum     (add_sum),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Operands are integer-valued singles, so the sum is exact integer math.
    function automatic logic [31:0] i2f(int v);
        logic [31:0] m;
        logic [31:0] r;
        int p;
        if (v == 0) return FP_ZERO;
        m = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'(m << (23 - p));
        return r;
    endfunction

    function automatic int f2i(logic [31:0] f);
        int p;
        int mag;
        if (f[30:23] == 8'd0) return 0;
        p   = int'(f[30:23]) - 127;
        mag = int'({8'd0, 1'b1, f[22:0]} >> (23 - p));
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b);
        if ((a[30:23] == 8'hFF && a[22:0] != 0) ||
            (b[30:23] == 8'hFF && b[22:0] != 0))
            return FP_QNAN;
        return i2f(f2i(a) + f2i(b));
    endfunction

    // Free-running adder: rise, sample A, sample B, compute, rise again.
    int          am_ph;
    int          am_cnt;
    int          nz_win = 0;
    logic [31:0] am_a;
    logic [31:0] am_b;
    bit          stuck = 1'b0;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            add_ready <= 1'b0;
            add_sum   <= 32'h0;
            am_ph     <= 0;
            am_cnt    <= 3;
        end else begin
            case (am_ph)
                0: begin
                    if (am_cnt == 0) begin
                        add_ready <= 1'b1;
                        am_ph     <= 1;
                    end else begin
                        am_cnt <= am_cnt - 1;
                    end
                end
                1: am_ph <= 2;
                2: begin
                    am_a      <= add_a;
                    add_ready <= 1'b0;
                    am_ph     <= 3;
                end
                3: begin
                    if (am_a != 0 || add_a != 0) nz_win <= nz_win + 1;
                    am_b    <= add_a;
                    add_sum <= $urandom;
                    am_cnt  <= (am_a == 0 && add_a == 0) ? 2 : int'($urandom_range(3, 9));
                    am_ph   <= 4;
                end
                4: begin
                    if (!stuck) begin
                        if (am_cnt == 0) begin
                            add_sum <= ref_add(am_a, am_b);
                            am_ph   <= 5;
                        end else begin
                            am_cnt <= am_cnt - 1;
                        end
                    end
                end
                default: begin
                    add_ready <= 1'b1;
                    am_ph     <= 1;
                end
            endcase
        end
    end

    // res_ready: 0 always high, 1 random, 2 held low, 3 one-cycle pulse.
    int rr_mode = 0;

    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rr_mode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = 1'($urandom_range(0, 1));
                3: begin
                    bus.res_ready = 1'b1;
                    rr_mode = 2;
                end
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clock) begin
        logic [31:0] e;
        if (nreset && bus.res_valid && bus.res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_result: got %h, none expected", bus.res_sum);
            end else begin
                e = exp_q.pop_front();
                if (bus.res_sum !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", bus.res_sum, e);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_op(logic [31:0] a, logic [31:0] b);
        int n = 0;
        @(posedge clock);
        #1;
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.op_ready && n < 3000);
        checks++;
        if (!bus.op_ready) begin
            errors++;
            $display("FAIL op_accept: op_ready=0 after %0d cycles, required 1", n);
            bus.op_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        bus.op_valid = 1'b0;
        exp_q.push_back(ref_add(a, b));
    endtask

    task automatic wait_ph(int ph, int lim, string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (am_ph != ph && n < lim);
        checks++;
        if (am_ph != ph) begin
            errors++;
            $display("FAIL %s: adder phase %0d after %0d cycles, required %0d", name, am_ph, n, ph);
        end
    endtask

    task automatic wait_drain(int lim, string name);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    function automatic int rnd_int();
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    initial begin
        int n;
        int base;
        bus.op_valid = 1'b0;
        bus.op_a     = 32'h0;
        bus.op_b     = 32'h0;

        repeat (3) @(negedge clock);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_op_ready", 32'(bus.op_ready), 32'h1);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_res_sum", bus.res_sum, 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        nreset = 1'b1;

        repeat (100) begin
            @(negedge clock);
            checks++;
            if (add_a !== 32'h0 || bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle: add_a=%h res_valid=%b op_ready=%b, required 0/0/1",
                         add_a, bus.res_valid, bus.op_ready);
            end
        end

        send_op(32'h3F80_0000, 32'h4000_0000);
        wait_ph(1, 200, "basic_rise");
        @(negedge clock);
        chk("basic_a_r1", add_a, 32'h3F80_0000);
        @(negedge clock);
        chk("basic_b_r2", add_a, 32'h4000_0000);
        wait_drain(200, "basic");

        send_op(32'h7FC0_0000, 32'h3F80_0000);
        wait_drain(200, "nan");
        send_op(32'h0000_0000, 32'hC0A0_0000);
        wait_drain(200, "zero");

        rr_mode = 2;
        base = nz_win;
        send_op(32'h3F80_0000, 32'h4000_0000);
        send_op(i2f(3), i2f(4));
        n = 0;
        while (!bus.res_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (40) @(negedge clock);
        chk("bp_held_valid", 32'(bus.res_valid), 32'h1);
        chk("bp_held_sum", bus.res_sum, 32'h4040_0000);
        chk("bp_pending", 32'(bus.op_ready), 32'h0);
        chk("bp_windows_before", 32'(nz_win - base), 32'd1);
        rr_mode = 3;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.res_valid && n < 20);
        rr_mode = 0;
        wait_drain(300, "bp");
        chk("bp_windows_after", 32'(nz_win - base), 32'd2);

        rr_mode = 1;
        for (int i = 0; i < 25; i++) begin
            send_op(i2f(rnd_int()), i2f(rnd_int()));
            repeat ($urandom_range(0, 20)) @(posedge clock);
        end
        wait_drain(3000, "random");
        rr_mode = 0;
        repeat (5) @(negedge clock);

        send_op(i2f(7), i2f(9));
        wait_ph(4, 200, "rst_busy");
        nreset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        chk("midrst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("midrst_op_ready", 32'(bus.op_ready), 32'h1);
        chk("midrst_add_a", add_a, 32'h0);
        chk("midrst_res_sum", bus.res_sum, 32'h0);
        nreset = 1'b1;
        repeat (60) @(negedge clock);
        chk("midrst_no_result", 32'(bus.res_valid), 32'h0);

`ifdef FPADDER_DRV_TIMEOUT_EN
        stuck = 1'b1;
        send_op(i2f(5), i2f(6));
        wait_ph(4, 200, "to_busy");
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("to_flag", 32'(timeout_err), 32'h1);
        checks++;
        if (n < 14 || n > 19) begin
            errors++;
            $display("FAIL to_cycles: flag after %0d cycles, required 14..19", n);
        end
        exp_q.delete();
        chk("to_res_valid", 32'(bus.res_valid), 32'h0);
        chk("to_op_ready", 32'(bus.op_ready), 32'h1);
        stuck = 1'b0;
        repeat (40) @(negedge clock);
        chk("to_no_result", 32'(bus.res_valid), 32'h0);
        chk("to_sticky", 32'(timeout_err), 32'h1);
`else
        chk("timeout_tied", 32'(timeout_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
